// File: rtl/fifo_rd_axis.sv
// Read-side drain stage: turns the FIFO rd_en/dout/valid interface into a framed valid/ready stream.
// Optional delivered-beat counter is built when FIFO_RD_AXIS_STAT_EN is defined.
module fifo_rd_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int BUF_AW     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  idle,
    output logic                  err_unexpected,
    output logic [31:0]           stat_beats
);

    localparam int DEPTH = 1 << BUF_AW;
    localparam logic [BUF_AW:0] DEPTH_C = (BUF_AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [BUF_AW:0]       count;
    logic [BUF_AW:0]       occupancy;
    logic [BUF_AW-1:0]     rptr;
    logic [BUF_AW-1:0]     wptr;
    logic                  inflight;
    logic                  pop;
    logic                  capture;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  len_lat;
    logic [LEN_WIDTH-1:0]  len_cfg;
    logic [LEN_WIDTH-1:0]  len_eff;

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? LEN_WIDTH'(1) : len;
    endfunction

    assign pop     = m_tvalid & m_tready;
    assign capture = fifo_valid & inflight;

    // Count the slot freed by this cycle's pop so a full buffer still reads every cycle.
    assign occupancy  = count - {{BUF_AW{1'b0}}, pop} + {{BUF_AW{1'b0}}, inflight};
    assign fifo_rd_en = ~rst & enable & ~fifo_empty & (occupancy < DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            rptr           <= '0;
            wptr           <= '0;
            inflight       <= 1'b0;
            beat_cnt       <= '0;
            len_lat        <= LEN_WIDTH'(1);
            err_unexpected <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            count    <= count + {{BUF_AW{1'b0}}, capture} - {{BUF_AW{1'b0}}, pop};
            if (capture) begin
                wptr <= wptr + BUF_AW'(1);
            end
            if (pop) begin
                rptr     <= rptr + BUF_AW'(1);
                beat_cnt <= m_tlast ? '0 : beat_cnt + LEN_WIDTH'(1);
                if (beat_cnt == '0) begin
                    len_lat <= len_cfg;
                end
            end
            if (fifo_valid & ~inflight) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // Buffer storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (capture & ~rst) begin
            mem[wptr] <= fifo_dout;
        end
    end

    assign len_cfg  = clamp_len(cfg_burst_len);
    assign len_eff  = (beat_cnt == '0) ? len_cfg : len_lat;
    assign m_tvalid = (count != '0);
    assign m_tdata  = m_tvalid ? mem[rptr] : '0;
    assign m_tlast  = m_tvalid & (beat_cnt == len_eff - LEN_WIDTH'(1));
    assign idle     = (count == '0) & ~inflight;

`ifdef FIFO_RD_AXIS_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (pop && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_beats = stat_q;
`else
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_axis.sv
// Directed bench for fifo_rd_axis with a behavioural FIFO read-side model and stream monitor.
module tb_fifo_rd_axis;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  cfg_burst_len;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        idle;
    logic        err_unexpected;
    logic [31:0] stat_beats;

    fifo_rd_axis #(.DATA_WIDTH(8), .LEN_WIDTH(8), .BUF_AW(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_burst_len(cfg_burst_len),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
        .fifo_empty(fifo_empty), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .idle(idle),
        .err_unexpected(err_unexpected), .stat_beats(stat_beats)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] fq [$];
    logic [7:0] bd [$];
    logic       bl [$];
    int         bc [$];
    logic       rd_s = 1'b0;
    logic       inject = 1'b0;
    int         cyc = 0;
    int         rd_total = 0;
    int         occ = 0;
    int         ovf = 0;
    int         stab_err = 0;
    int         underflow = 0;
    int         first_rd = -1;
    int         first_v = -1;
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = '0;

    // Read side of the FIFO: data and valid one cycle after an accepted read.
    initial begin
        fifo_valid = 1'b0;
        fifo_dout  = '0;
        fifo_empty = 1'b1;
    end

    always @(posedge clk) begin
        cyc++;
        if (rd_s) begin
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            else underflow++;
            fifo_valid <= 1'b1;
        end else if (inject) begin
            fifo_dout  <= 8'hEE;
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        rd_s = fifo_rd_en;
        if (rst) begin
            occ       = 0;
            hold_prev = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rd_total++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_tvalid && first_v < 0) first_v = cyc;
            if (hold_prev && (!m_tvalid || m_tdata !== data_prev)) stab_err++;
            if (m_tvalid && m_tready) begin
                bd.push_back(m_tdata);
                bl.push_back(m_tlast);
                bc.push_back(cyc);
            end
            occ = occ + (fifo_rd_en ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
            if (occ > 2) ovf++;
            hold_prev = m_tvalid && !m_tready;
            data_prev = m_tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int maxc, input string tag);
        int k = 0;
        while (bd.size() < n && k < maxc) begin
            step();
            k++;
        end
        chk(tag, bd.size(), n);
    endtask

    task automatic clear_mon();
        bd.delete();
        bl.delete();
        bc.delete();
    endtask

    int rdbase;
    int exp_stat;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        m_tready = 1'b0;
        cfg_burst_len = 8'd4;
        for (int i = 1; i <= 16; i++) fq.push_back(8'(i));

        // Reset state, with the FIFO already non-empty and enable high
        step();
        step();
        @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_unexpected, 0);
        chk("rst_stat", stat_beats, 0);

        // Streaming 16 words, bursts of 4
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        wait_beats(16, 100, "stream_cnt");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stream_data%0d", i), bd[i], i + 1);
            chk($sformatf("stream_last%0d", i), bl[i], (i % 4 == 3) ? 1 : 0);
        end
        chk("stream_latency", first_v - first_rd, 2);
        chk("stream_nobubble", bc[15] - bc[0], 15);
        repeat (3) step();
        chk("stream_idle", idle, 1);

        // Backpressure with ready pattern 1,0,0,1
        clear_mon();
        cfg_burst_len = 8'd3;
        for (int i = 0; i < 12; i++) fq.push_back(8'h20 + 8'(i));
        for (int c = 0; c < 200 && bd.size() < 12; c++) begin
            m_tready = (c % 4 == 0) || (c % 4 == 3);
            step();
        end
        chk("bp_cnt", bd.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("bp_data%0d", i), bd[i], 8'h20 + i);
            chk($sformatf("bp_last%0d", i), bl[i], (i % 3 == 2) ? 1 : 0);
        end
        chk("bp_occupancy", ovf, 0);
        chk("bp_stable", stab_err, 0);
        m_tready = 1'b1;

        // Zero burst length: every beat is last
        clear_mon();
        cfg_burst_len = 8'd0;
        for (int i = 0; i < 4; i++) fq.push_back(8'h30 + 8'(i));
        wait_beats(4, 50, "len0_cnt");
        for (int i = 0; i < 4; i++) chk($sformatf("len0_last%0d", i), bl[i], 1);
        chk("len0_data3", bd[3], 8'h33);

        // Length 3 -> 5 after the first beat of a burst
        clear_mon();
        cfg_burst_len = 8'd3;
        for (int i = 0; i < 8; i++) fq.push_back(8'h38 + 8'(i));
        for (int c = 0; c < 60 && bd.size() < 8; c++) begin
            cfg_burst_len = (bd.size() >= 1) ? 8'd5 : 8'd3;
            step();
        end
        chk("lenchg_cnt", bd.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("lenchg_last%0d", i), bl[i], (i == 2 || i == 7) ? 1 : 0);

        // Enable gating after 5 reads
        clear_mon();
        enable = 1'b0;
        cfg_burst_len = 8'd4;
        for (int i = 0; i < 10; i++) fq.push_back(8'h40 + 8'(i));
        step();
        rdbase = rd_total;
        for (int c = 0; c < 30; c++) begin
            enable = (rd_total - rdbase) < 5;
            step();
        end
        chk("en_reads", rd_total - rdbase, 5);
        chk("en_beats", bd.size(), 5);
        chk("en_idle", idle, 1);
        chk("en_fifo_nonempty", fifo_empty, 0);
        chk("en_data4", bd[4], 8'h44);
        enable = 1'b1;
        wait_beats(10, 60, "en_resume_cnt");
        chk("en_data5", bd[5], 8'h45);
        chk("en_data9", bd[9], 8'h49);
        chk("en_last4", bl[4], 0);
        chk("en_last7", bl[7], 1);

        // Unexpected data with no read outstanding
        clear_mon();
        enable = 1'b0;
        inject = 1'b1;
        step();
        inject = 1'b0;
        repeat (4) step();
        chk("err_set", err_unexpected, 1);
        chk("err_no_beat", bd.size(), 0);
        chk("err_tvalid", m_tvalid, 0);
        repeat (5) step();
        chk("err_sticky", err_unexpected, 1);

        // Reset mid-burst
        clear_mon();
        enable = 1'b1;
        cfg_burst_len = 8'd4;
        for (int i = 0; i < 6; i++) fq.push_back(8'h60 + 8'(i));
        wait_beats(2, 40, "mid_pre_cnt");
        rst = 1'b1;
        m_tready = 1'b0;
        fq.delete();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tdata", m_tdata, 0);
        chk("mid_idle", idle, 1);
        chk("mid_err", err_unexpected, 0);
        chk("mid_stat", stat_beats, 0);
        step();
        clear_mon();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'h70 + 8'(i));
        wait_beats(4, 40, "post_cnt");
        chk("post_data0", bd[0], 8'h70);
        for (int i = 0; i < 4; i++) chk($sformatf("post_last%0d", i), bl[i], (i == 3) ? 1 : 0);

        // Delivered-beat counter: 4 pops so far plus 33 more
        for (int i = 0; i < 33; i++) fq.push_back(8'(i));
        wait_beats(37, 200, "stat_cnt");
        repeat (3) step();
`ifdef FIFO_RD_AXIS_STAT_EN
        exp_stat = 37;
`else
        exp_stat = 0;
`endif
        chk("stat_beats", stat_beats, exp_stat);
        chk("fifo_underflow", underflow, 0);
        chk("occupancy_all", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
